// File: rtl/smc_pkg.sv
// rtl/smc_pkg.sv - shared types and constants for the SMC loader
package smc_pkg;

  localparam int NUM_FET = 6;
  localparam int DW      = 3;
  localparam int OW      = 10;
  localparam int CW      = $clog2(NUM_FET);

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_FET - 1);

  typedef struct packed {
    logic [DW-1:0] w;
    logic [DW-1:0] vgs;
    logic [DW-1:0] vds;
  } fet_param_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    ISSUE,
    HOLD
  } loader_state_e;

  // A FET with zero width or zero gate drive cannot be evaluated meaningfully.
  function automatic logic fet_out_of_range(fet_param_t f);
    return (f.w == '0) || (f.vgs == '0);
  endfunction

endpackage

// File: rtl/smc_loader_if.sv
// rtl/smc_loader_if.sv - parameter stream, calculator port and result handshake
interface smc_loader_if;
  import smc_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [DW-1:0]         in_w;
  logic [DW-1:0]         in_vgs;
  logic [DW-1:0]         in_vds;

  logic                  smc_valid;
  logic [1:0]            smc_mode;
  logic [NUM_FET*DW-1:0] smc_w;
  logic [NUM_FET*DW-1:0] smc_vgs;
  logic [NUM_FET*DW-1:0] smc_vds;
  logic [OW-1:0]         smc_out_n;

  logic                  out_valid;
  logic                  out_ready;
  logic [OW-1:0]         out_data;
  logic                  out_err;

  modport slave (
    input  in_valid, in_mode, in_w, in_vgs, in_vds, smc_out_n, out_ready,
    output in_ready, smc_valid, smc_mode, smc_w, smc_vgs, smc_vds,
           out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_mode, in_w, in_vgs, in_vds, smc_out_n, out_ready,
    input  in_ready, smc_valid, smc_mode, smc_w, smc_vgs, smc_vds,
           out_valid, out_data, out_err
  );

endinterface

// File: rtl/smc_frame_reg.sv
// rtl/smc_frame_reg.sv - NUM_FET-entry FET parameter register file with packed outputs
module smc_frame_reg
  import smc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [CW-1:0]         idx_i,
  input  fet_param_t            fet_i,
  output logic [NUM_FET*DW-1:0] w_o,
  output logic [NUM_FET*DW-1:0] vgs_o,
  output logic [NUM_FET*DW-1:0] vds_o
);

  logic [NUM_FET-1:0][DW-1:0] w_q;
  logic [NUM_FET-1:0][DW-1:0] vgs_q;
  logic [NUM_FET-1:0][DW-1:0] vds_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q   <= '0;
      vgs_q <= '0;
      vds_q <= '0;
    end else if (we_i && (idx_i <= LAST_IDX)) begin
      w_q[idx_i]   <= fet_i.w;
      vgs_q[idx_i] <= fet_i.vgs;
      vds_q[idx_i] <= fet_i.vds;
    end
  end

  // Entry k lands on bits [k*DW +: DW] of each packed bus.
  assign w_o   = w_q;
  assign vgs_o = vgs_q;
  assign vds_o = vds_q;

endmodule

// File: rtl/smc_loader.sv
// rtl/smc_loader.sv - beat-serial frame loader and result register for the SMC calculator
// Optional range check built when SMC_LOADER_RANGE_CHECK_EN is defined.
module smc_loader
  import smc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  smc_loader_if.slave bus
);

  loader_state_e state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ready_q;
  logic          smc_valid_q;
  logic [1:0]    smc_mode_q;
  logic          out_valid_q;
  logic [OW-1:0] out_data_q;
  logic          accept;
  fet_param_t    fet_d;

  assign accept  = bus.in_valid & ready_q;
  assign count_d = count_q + CW'(1);
  assign fet_d   = '{w: bus.in_w, vgs: bus.in_vgs, vds: bus.in_vds};

  smc_frame_reg u_frame (
    .clk   (clk),
    .reset (reset),
    .we_i  (accept),
    .idx_i (count_q),
    .fet_i (fet_d),
    .w_o   (bus.smc_w),
    .vgs_o (bus.smc_vgs),
    .vds_o (bus.smc_vds)
  );

  // ready_q comes up one edge after reset release, so IDLE sets it every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ready_q     <= 1'b0;
      smc_valid_q <= 1'b0;
      smc_mode_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            smc_mode_q <= bus.in_mode;
            count_q    <= count_d;
            state_q    <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (count_q == LAST_IDX) begin
              count_q     <= '0;
              ready_q     <= 1'b0;
              smc_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              count_q <= count_d;
            end
          end
        end
        ISSUE: begin
          smc_valid_q <= 1'b0;
          out_data_q  <= bus.smc_out_n;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.smc_valid = smc_valid_q;
  assign bus.smc_mode  = smc_mode_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef SMC_LOADER_RANGE_CHECK_EN
  logic err_q;
  logic out_err_q;
  logic beat_bad;

  assign beat_bad = fet_out_of_range(fet_d);

  // The sticky flag restarts on beat 0 so one bad frame never taints the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= (state_q == IDLE) ? beat_bad : (err_q | beat_bad);
      end
      if (state_q == ISSUE) begin
        out_err_q <= err_q;
      end else if ((state_q == HOLD) && bus.out_ready) begin
        out_err_q <= 1'b0;
      end
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_smc_loader.sv
// tb/tb_smc_loader.sv - randomized self-checking bench for smc_loader with a calculator stub
module tb_smc_loader;
  import smc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [DW-1:0] fw [NUM_FET];
  logic [DW-1:0] fv [NUM_FET];
  logic [DW-1:0] fd [NUM_FET];

  smc_loader_if ifc ();

  smc_loader dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Stand-in calculator: arbitrary per-mode arithmetic over the six FETs.
  function automatic logic [OW-1:0] calc(logic [1:0] m, logic [NUM_FET*DW-1:0] w,
                                         logic [NUM_FET*DW-1:0] g, logic [NUM_FET*DW-1:0] d);
    int sum = 0;
    for (int k = 0; k < NUM_FET; k++) begin
      int wk = int'(w[k*DW +: DW]);
      int gk = int'(g[k*DW +: DW]);
      int dk = int'(d[k*DW +: DW]);
      case (m)
        2'd0: sum += dk;
        2'd1: sum += (gk > dk) ? wk * (gk - dk) : 0;
        2'd2: sum += wk * gk;
        default: sum += wk + gk + dk;
      endcase
    end
    return OW'(sum);
  endfunction

  assign ifc.smc_out_n = calc(ifc.smc_mode, ifc.smc_w, ifc.smc_vgs, ifc.smc_vds);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fill_frame(input bit allow_zero);
    for (int k = 0; k < NUM_FET; k++) begin
      fw[k] = allow_zero ? DW'($urandom_range(0, 7)) : DW'($urandom_range(1, 7));
      fv[k] = allow_zero ? DW'($urandom_range(0, 7)) : DW'($urandom_range(1, 7));
      fd[k] = DW'($urandom_range(0, 7));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  ifc.in_ready, 0);
    check({tag, "_smc_valid"}, ifc.smc_valid, 0);
    check({tag, "_smc_mode"},  ifc.smc_mode, 0);
    check({tag, "_smc_w"},     ifc.smc_w, 0);
    check({tag, "_smc_vgs"},   ifc.smc_vgs, 0);
    check({tag, "_smc_vds"},   ifc.smc_vds, 0);
    check({tag, "_out_valid"}, ifc.out_valid, 0);
    check({tag, "_out_data"},  ifc.out_data, 0);
    check({tag, "_out_err"},   ifc.out_err, 0);
  endtask

  // Drives fw/fv/fd as one frame and checks issue, hold and release against the model.
  task automatic run_frame(input logic [1:0] mode, input int gap_pct, input int hold_n,
                           input bit ready_early, input bit glitch, output int t_first);
    logic [NUM_FET*DW-1:0] ew, ev, ed;
    logic [1:0]            emode;
    logic [OW-1:0]         exp_out;
    bit                    bad, exp_err;
    int                    idx, budget;
    idx = 0; budget = 0; bad = 0; t_first = -1;
    ew = '0; ev = '0; ed = '0; emode = mode;
    ifc.out_ready = ready_early;
    while (idx < NUM_FET && budget < 300) begin
      ifc.in_valid = (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) ? 1'b0 : 1'b1;
      ifc.in_w     = fw[idx];
      ifc.in_vgs   = fv[idx];
      ifc.in_vds   = fd[idx];
      if (idx == 0)               ifc.in_mode = mode;
      else if (glitch && idx == 2) ifc.in_mode = ~mode;
      else                        ifc.in_mode = 2'($urandom);
      if (ifc.in_valid && ifc.in_ready) begin
        if (idx == 0) t_first = cyc;
        ew[idx*DW +: DW] = fw[idx];
        ev[idx*DW +: DW] = fv[idx];
        ed[idx*DW +: DW] = fd[idx];
        if (fw[idx] == 0 || fv[idx] == 0) bad = 1;
        idx++;
      end
      step();
      budget++;
    end
    check("beats_accepted", idx, NUM_FET);
`ifdef SMC_LOADER_RANGE_CHECK_EN
    exp_err = bad;
`else
    exp_err = 0;
`endif
    exp_out = calc(emode, ew, ev, ed);

    ifc.in_valid = 1'b1;
    ifc.in_w = 3'($urandom); ifc.in_vgs = 3'($urandom); ifc.in_vds = 3'($urandom);
    check("issue_smc_valid", ifc.smc_valid, 1);
    check("issue_in_ready",  ifc.in_ready, 0);
    check("issue_out_valid", ifc.out_valid, 0);
    check("issue_smc_mode",  ifc.smc_mode, emode);
    check("issue_smc_w",     ifc.smc_w, ew);
    check("issue_smc_vgs",   ifc.smc_vgs, ev);
    check("issue_smc_vds",   ifc.smc_vds, ed);
    step();
    check("hold_smc_valid", ifc.smc_valid, 0);
    check("hold_out_valid", ifc.out_valid, 1);
    check("hold_out_data",  ifc.out_data, exp_out);
    check("hold_out_err",   ifc.out_err, exp_err);
    check("hold_in_ready",  ifc.in_ready, 0);
    ifc.out_ready = (hold_n == 0);
    for (int i = 0; i < hold_n; i++) begin
      step();
      check("stall_out_valid", ifc.out_valid, 1);
      check("stall_out_data",  ifc.out_data, exp_out);
      check("stall_out_err",   ifc.out_err, exp_err);
      check("stall_in_ready",  ifc.in_ready, 0);
      check("stall_smc_w",     ifc.smc_w, ew);
      check("stall_smc_vgs",   ifc.smc_vgs, ev);
      ifc.out_ready = (i == hold_n - 1);
    end
    step();
    check("done_out_valid", ifc.out_valid, 0);
    check("done_in_ready",  ifc.in_ready, 1);
    check("done_out_err",   ifc.out_err, 0);
    check("done_smc_w_kept", ifc.smc_w, ew);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = ready_early;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, seen;
    ifc.in_valid = 0; ifc.in_mode = 0; ifc.in_w = 0; ifc.in_vgs = 0; ifc.in_vds = 0;
    ifc.out_ready = 0;
    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();
    check("rst_release_in_ready", ifc.in_ready, 1);

    for (int k = 0; k < NUM_FET; k++) begin fw[k] = 1; fv[k] = 3; fd[k] = 1; end
    run_frame(2'b01, 0, 0, 0, 0, t0);
    check("frame1_out_data", ifc.out_data, 12);

    for (int k = 0; k < NUM_FET; k++) begin fw[k] = 3; fv[k] = 3; fd[k] = 1; end
    run_frame(2'b00, 40, 0, 0, 0, t0);
    check("frame2_smc_w", ifc.smc_w, 18'o333333);
    check("frame2_out_data", ifc.out_data, 6);

    fill_frame(0);
    run_frame(2'($urandom), 0, 20, 0, 0, t0);

    // Reset in the middle of a frame.
    fill_frame(0);
    seen = 0;
    for (int k = 0; k < 3 && seen < 50; seen++) begin
      ifc.in_valid = 1; ifc.in_mode = 2'b11;
      ifc.in_w = fw[k]; ifc.in_vgs = fv[k]; ifc.in_vds = fd[k];
      if (ifc.in_ready) k++;
      step();
    end
    ifc.in_valid = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ifc.smc_valid) seen++;
    end
    check("midrst_no_issue", seen, 0);
    rst_n = 1'b1;
    step();
    check("midrst_release_in_ready", ifc.in_ready, 1);
    fill_frame(0);
    run_frame(2'b10, 20, 2, 0, 0, t0);

    // Back-to-back frames, out_ready held high throughout.
    fill_frame(0);
    run_frame(2'($urandom), 0, 0, 1, 0, t0);
    fill_frame(0);
    run_frame(2'($urandom), 0, 0, 1, 1, t1);
    fill_frame(0);
    run_frame(2'($urandom), 0, 0, 1, 1, t2);
    check("b2b_period_1", t1 - t0, NUM_FET + 2);
    check("b2b_period_2", t2 - t1, NUM_FET + 2);

    // Range-check frames: W=0 on beat 4, then a clean frame.
    fill_frame(0);
    fw[4] = 0;
    run_frame(2'b01, 10, 1, 0, 0, t0);
    fill_frame(0);
    run_frame(2'b01, 10, 1, 0, 0, t0);
    fill_frame(0);
    fv[0] = 0;
    run_frame(2'b11, 0, 0, 0, 0, t0);

    for (int n = 0; n < 6; n++) begin
      fill_frame(1);
      run_frame(2'($urandom), int'($urandom_range(0, 50)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), t0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smc_loader.md
Name: smc_loader

Overview:
- Sequential front-end for the combinational MOSFET calculator (SMC).
- Accepts transistor parameters one FET per beat on a valid/ready stream and assembles a full 6-FET frame.
- Presents the frame in parallel to the calculator with a one-cycle valid strobe, then registers the returned 10-bit result.
- Returns the result on a valid/ready output handshake; this is the producer/consumer end of the calculator's parallel interface.

Parameters:
- NUM_FET, 6, FETs per frame; the beat counter runs 0..NUM_FET-1.
- DW, 3, width of W, V_GS and V_DS fields.
- OW, 10, width of the calculator result.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  parameter beat valid.
- in_ready  out  1  loader can accept a beat.
- in_mode  in  2  frame mode; sampled on beat 0 only.
- in_w, in_vgs, in_vds  in  DW each  parameters of the current FET.
- smc_valid  out  1  one-cycle strobe to the calculator.
- smc_mode  out  2  registered frame mode.
- smc_w, smc_vgs, smc_vds  out  NUM_FET*DW each  packed frame; FET k occupies bits [k*DW +: DW].
- smc_out_n  in  OW  calculator result; combinational response to smc_* inputs.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OW  registered result.
- out_err  out  1  frame range error (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat count=0, in_ready=0 while reset is asserted and 1 on the first cycle after release. smc_valid=0, out_valid=0, out_data=0, out_err=0, and smc_mode/smc_w/smc_vgs/smc_vds=0.
- FSM states are IDLE, COLLECT, ISSUE and HOLD.
- IDLE: in_ready=1. An accepted beat (in_valid & in_ready) stores FET 0 and in_mode, sets count=1, and moves to COLLECT.
- COLLECT: in_ready=1. Each accepted beat stores FET[count] and increments count. Gaps (in_valid=0) are allowed indefinitely. The beat stored at count=NUM_FET-1 moves to ISSUE and clears count.
- ISSUE: lasts exactly one cycle. in_ready=0, smc_valid=1, and the frame registers are stable. out_data captures smc_out_n at the end of this cycle. Go to HOLD.
- HOLD: in_ready=0, out_valid=1, and out_data/out_err are held stable. When out_ready=1, go to IDLE; out_valid=0 and in_ready=1 on the next cycle.
- Latency: the last beat is accepted at edge T, smc_valid is high during cycle T+1, and out_valid is high from cycle T+2.
- Minimum frame period is NUM_FET+2 cycles with no stalls.
- Frame registers keep their contents after a frame. Only accepted beats overwrite them, so smc_* stay stable in HOLD.
- in_mode is ignored on beats 1..NUM_FET-1.
- Reset asserted mid-frame: the partial frame is discarded and all outputs go to their reset values. No smc_valid is issued.
- out_ready may be high before out_valid; it is ignored outside HOLD.

Optional Feature:
- Macro: SMC_LOADER_RANGE_CHECK_EN.
- Defined: any accepted beat with W==0 or V_GS==0 sets a frame-sticky error flag. The flag clears at the first beat of the next frame. out_err carries the flag alongside out_data in HOLD and is 0 otherwise. The frame is still issued.
- Undefined: out_err is tied to 0 and no check logic is built.

Decomposition:
- Shared package smc_pkg:
  - fet_param_t struct {w, vgs, vds} of DW bits each.
  - loader_state_e enum {IDLE, COLLECT, ISSUE, HOLD}.
  - Constants NUM_FET=6, DW=3, OW=10.
- One sub-module, smc_frame_reg: NUM_FET-entry parameter register file with write-enable and index, exposing the packed outputs.
- FSM, counter and result register stay in smc_loader.

Test Plan:
- Frame: 6 beats of W=1, V_GS=3, V_DS=1, mode=2'b01, with the calculator model attached -> smc_valid for exactly 1 cycle, 1 cycle after the last beat; out_valid the next cycle; out_data=12.
- Frame: W=3, V_GS=3, V_DS=1, mode=2'b00, random in_valid gaps -> packed smc_w=18'o333333; out_data=6; in_ready=0 from ISSUE until the out_ready handshake.
- out_ready held 0 for 20 cycles in HOLD, with in_valid held 1 -> out_valid and out_data stable; no beats accepted; frame registers unchanged.
- Reset asserted after 3 beats -> all outputs reset immediately. Next full 6-beat frame produces a correct result using only new data and a mode taken from its own beat 0.
- Back-to-back frames with out_ready=1 constant -> one result every 8 cycles; second frame's in_mode change on beat 2 is ignored.
- With SMC_LOADER_RANGE_CHECK_EN defined, beat 4 with W=0 -> out_err=1 with out_data. Next clean frame -> out_err=0. Without the macro -> out_err always 0.
